// File: rtl/dispatch_my_action.sv
// Per-packet dispatcher: reads back and clears the forAggregation flag.
// Set flag -> bump the aggregation counter. Clear flag -> hand the action to the transmitter.
module dispatch_my_action #(
   parameter int WORD_WIDTH    = 16,
   parameter int ADDR_WIDTH    = 11,
   parameter int FLAG_ADDR     = 2,
   parameter int CNT_ADDR      = 3,
   parameter int AGG_THRESHOLD = 4,
   parameter int SINK_ID       = 65
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] action,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  wr_en,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [WORD_WIDTH-1:0] tx_dest,
   output logic                  agg_fire,
   output logic                  err,
   output logic                  done
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ARMED    = 4'd1;
   localparam logic [3:0] S_RD_FLAG  = 4'd2;
   localparam logic [3:0] S_CHK_FLAG = 4'd3;
   localparam logic [3:0] S_CLR_FLAG = 4'd4;
   localparam logic [3:0] S_RD_CNT   = 4'd5;
   localparam logic [3:0] S_CHK_CNT  = 4'd6;
   localparam logic [3:0] S_WR_CNT   = 4'd7;
   localparam logic [3:0] S_SEND     = 4'd8;
   localparam logic [3:0] S_FIN      = 4'd9;

   localparam logic [WORD_WIDTH-1:0] THR_M1   = WORD_WIDTH'(AGG_THRESHOLD - 1);
   localparam logic [WORD_WIDTH-1:0] SINK     = WORD_WIDTH'(SINK_ID);
   localparam logic [ADDR_WIDTH-1:0] A_FLAG   = ADDR_WIDTH'(FLAG_ADDR);
   localparam logic [ADDR_WIDTH-1:0] A_CNT    = ADDR_WIDTH'(CNT_ADDR);

   logic [3:0]            state;
   logic [WORD_WIDTH-1:0] act_q;
   logic                  wrap;

   // A corrupt counter at or above the threshold is treated like a full one.
   assign wrap = (data_in >= THR_M1);

   // Outputs are registered on the transition into the state that presents them.
   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= S_IDLE;
         act_q    <= '0;
         address  <= '0;
         wr_en    <= 1'b0;
         data_out <= '0;
         tx_valid <= 1'b0;
         tx_dest  <= '0;
         agg_fire <= 1'b0;
         err      <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         agg_fire <= 1'b0;
         case (state)
            S_IDLE: if (en) begin
               done    <= 1'b0;
               err     <= 1'b0;
               tx_dest <= '0;
               state   <= S_ARMED;
            end
            S_ARMED: if (start) begin
               act_q   <= action;
               address <= A_FLAG;
               state   <= S_RD_FLAG;
            end
            S_RD_FLAG: state <= S_CHK_FLAG;
            S_CHK_FLAG: begin
               if (data_in[0]) begin
                  data_out <= '0;
                  wr_en    <= 1'b1;
                  state    <= S_CLR_FLAG;
               end else if (act_q == SINK) begin
                  // Unflagged packet addressed to ourselves: nothing valid to send.
                  err     <= 1'b1;
                  done    <= 1'b1;
                  address <= '0;
                  state   <= S_FIN;
               end else begin
                  tx_valid <= 1'b1;
                  tx_dest  <= act_q;
                  state    <= S_SEND;
               end
            end
            S_CLR_FLAG: begin
               address <= A_CNT;
               state   <= S_RD_CNT;
            end
            S_RD_CNT: state <= S_CHK_CNT;
            S_CHK_CNT: begin
               data_out <= wrap ? '0 : data_in + WORD_WIDTH'(1);
               agg_fire <= wrap;
               wr_en    <= 1'b1;
               state    <= S_WR_CNT;
            end
            S_WR_CNT: begin
               address <= '0;
               done    <= 1'b1;
               state   <= S_FIN;
            end
            S_SEND: if (tx_ready) begin
               tx_valid <= 1'b0;
               address  <= '0;
               done     <= 1'b1;
               state    <= S_FIN;
            end
            S_FIN: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dispatch_my_action.sv
// Directed bench for dispatch_my_action with a small synchronous memory model.
module tb_dispatch_my_action;

   logic        clk, rst, en, start, tx_ready;
   logic [15:0] action, data_in, data_out, tx_dest;
   logic [10:0] address;
   logic        wr_en, tx_valid, agg_fire, err, done;

   dispatch_my_action dut (
      .clock(clk), .rst(rst), .en(en), .start(start), .action(action),
      .data_in(data_in), .address(address), .wr_en(wr_en), .data_out(data_out),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest),
      .agg_fire(agg_fire), .err(err), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: registered read, preload port for the bench
   logic [15:0] mem [0:15];
   logic        pl_we;
   logic [3:0]  pl_a;
   logic [15:0] pl_d;
   always @(posedge clk) begin
      if (pl_we) mem[pl_a] <= pl_d;
      else if (wr_en) mem[address[3:0]] <= data_out;
      data_in <= mem[address[3:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // bus monitors, sampled mid-cycle
   logic [10:0] wa [0:127];
   logic [15:0] wd [0:127];
   int nw = 0, fires = 0, fire_bad = 0, txv = 0, dchg = 0;
   logic [15:0] last_dest = '0;
   logic        prev_v = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            wa[nw[6:0]] = address;
            wd[nw[6:0]] = data_out;
            nw++;
         end
         if (agg_fire) begin
            fires++;
            if (!(wr_en && address == 11'd3)) fire_bad++;
         end
         if (tx_valid) begin
            txv++;
            if (prev_v && tx_dest != last_dest) dchg++;
            last_dest = tx_dest;
         end
      end
      prev_v = tx_valid;
   end

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int a, input logic [15:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_a = a[3:0]; pl_d = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   // returns the cycle (1 = first cycle after the start edge) in which done is seen
   task automatic dispatch(input logic [15:0] act, output int lat);
      lat = -1;
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0; action = act; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i < 60; i++) begin
         if (done) begin lat = i; break; end
         @(negedge clk);
      end
      if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   int lat, n0, f0, v0, w;

   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b0; tx_ready = 1'b1; action = '0;
      pl_we = 1'b0; pl_a = '0; pl_d = '0;
      repeat (3) @(negedge clk);
      chk("rst_addr", 32'(address), 0); chk("rst_wr", 32'(wr_en), 0);
      chk("rst_dout", 32'(data_out), 0); chk("rst_txv", 32'(tx_valid), 0);
      chk("rst_dest", 32'(tx_dest), 0); chk("rst_fire", 32'(agg_fire), 0);
      chk("rst_err", 32'(err), 0); chk("rst_done", 32'(done), 0);
      rst = 1'b0;

      // flag set, counter 0 -> clear flag, counter becomes 1
      poke(2, 16'h0001); poke(3, 16'h0000);
      n0 = nw; f0 = fires; v0 = txv;
      dispatch(16'h0007, lat);
      chk("flag_lat", 32'(lat), 7);
      chk("flag_nwr", 32'(nw - n0), 2);
      chk("flag_w0a", 32'(wa[n0]), 2); chk("flag_w0d", 32'(wd[n0]), 0);
      chk("flag_w1a", 32'(wa[n0+1]), 3); chk("flag_w1d", 32'(wd[n0+1]), 1);
      chk("flag_fire", 32'(fires - f0), 0); chk("flag_txv", 32'(txv - v0), 0);
      chk("flag_mem3", 32'(mem[3]), 1);

      // counter at threshold-1 and a corrupt large counter both wrap and fire
      for (int k = 0; k < 2; k++) begin
         poke(2, 16'h00F1); poke(3, (k == 0) ? 16'h0003 : 16'h00FF);
         n0 = nw; f0 = fires;
         dispatch(16'h0009, lat);
         chk("wrap_lat", 32'(lat), 7);
         chk("wrap_nwr", 32'(nw - n0), 2);
         chk("wrap_w1d", 32'(wd[n0+1]), 0);
         chk("wrap_fire", 32'(fires - f0), 1);
         chk("wrap_done", 32'(done), 1);
      end
      chk("fire_only_on_cnt_write", 32'(fire_bad), 0);

      // flag clear, transmitter stalls 5 cycles
      poke(2, 16'h0000);
      n0 = nw; v0 = txv; tx_ready = 1'b0;
      fork
         dispatch(16'h0012, lat);
         begin
            w = 0;
            while (w < 60 && !tx_valid) begin @(negedge clk); w++; end
            repeat (5) @(negedge clk);
            tx_ready = 1'b1;
         end
      join
      chk("send_lat", 32'(lat), 9);
      chk("send_txv_cycles", 32'(txv - v0), 6);
      chk("send_dest", 32'(last_dest), 32'h12);
      chk("send_dest_stable", 32'(dchg), 0);
      chk("send_nwr", 32'(nw - n0), 0);
      chk("send_txv_after", 32'(tx_valid), 0);

      // send path, ready throughout
      dispatch(16'h0021, lat);
      chk("send_fast_lat", 32'(lat), 4);
      chk("send_fast_dest", 32'(tx_dest), 32'h21);

      // flag clear with SINK_ID -> err, no send
      v0 = txv;
      dispatch(16'd65, lat);
      chk("sink_err", 32'(err), 1);
      chk("sink_done", 32'(done), 1);
      chk("sink_txv", 32'(txv - v0), 0);
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0;
      chk("sink_err_clr", 32'(err), 0);
      chk("sink_done_clr", 32'(done), 0);

      // reset during the flag clear write
      poke(2, 16'h0001); poke(3, 16'h0000);
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0; start = 1'b1; action = 16'h0005;
      @(negedge clk); start = 1'b0;
      w = 0;
      while (w < 20 && !(wr_en && address == 11'd2)) begin @(negedge clk); w++; end
      chk("clr_reached", 32'(wr_en), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_wr", 32'(wr_en), 0); chk("mid_rst_addr", 32'(address), 0);
      chk("mid_rst_dout", 32'(data_out), 0); chk("mid_rst_done", 32'(done), 0);
      rst = 1'b0;
      n0 = nw; v0 = txv;
      start = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b0;
      chk("nostart_nwr", 32'(nw - n0), 0);
      chk("nostart_txv", 32'(txv - v0), 0);
      chk("nostart_addr", 32'(address), 0);
      chk("nostart_done", 32'(done), 0);
      chk("rst_mem3_kept", 32'(mem[3]), 0);

      // five back-to-back flagged dispatches: only the 4th fires
      poke(3, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         poke(2, 16'h0001);
         f0 = fires;
         dispatch(16'h0003, lat);
         chk("b2b_fire", 32'(fires - f0), (k == 3) ? 1 : 0);
      end
      chk("b2b_cnt", 32'(mem[3]), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dispatch_my_action.md
Name: dispatch_my_action

Overview:
- Consumer-side counterpart to the action selector.
- After the selector has written the forAggregation flag word into node memory, this block reads the flag back and clears it.
- Flag set: maintains the per-node aggregation counter in memory and fires an aggregation pulse every AGG_THRESHOLD packets.
- Flag clear: hands the chosen action (next-hop/next-sink ID) to the packet transmitter through a valid/ready handshake.
- Uses the same en/start/done sequencing as the other per-packet blocks.

Parameters:
- WORD_WIDTH, 16, memory word and action width.
- ADDR_WIDTH, 11, memory address width.
- FLAG_ADDR, 2, address of the forAggregation flag word.
- CNT_ADDR, 3, address of the aggregation counter word.
- AGG_THRESHOLD, 4, packets per aggregation event (≥1).
- SINK_ID, 65, action value meaning "self / cluster head".

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arms the block; sampled only in IDLE.
- start  in  1  begins dispatch; sampled only in ARMED.
- action  in  WORD_WIDTH  action chosen by the selector; must be stable from start until done.
- data_in  in  WORD_WIDTH  memory read data, valid the cycle after address is driven.
- address  out  ADDR_WIDTH  memory address.
- wr_en  out  1  memory write strobe.
- data_out  out  WORD_WIDTH  memory write data.
- tx_valid  out  1  destination offered to the transmitter.
- tx_ready  in  1  transmitter accepts tx_dest.
- tx_dest  out  WORD_WIDTH  destination node ID.
- agg_fire  out  1  one-cycle pulse: aggregation threshold reached.
- err  out  1  inconsistency flag; held until the next en.
- done  out  1  dispatch complete; held until the next en.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; address=0, wr_en=0, data_out=0, tx_valid=0, tx_dest=0, agg_fire=0, err=0, done=0.
- Reset asserted mid-operation aborts immediately. No further writes and no tx_valid after that edge. The memory is left as-is.
- All outputs are registered/Moore; the values listed below hold during the named state.
- IDLE: en=1 → clear done, err, tx_dest; go to ARMED. Otherwise stay. start is ignored here.
- ARMED: start=1 → latch action into an internal register; go to RD_FLAG. en is ignored outside IDLE.
- RD_FLAG: address=FLAG_ADDR, wr_en=0 → CHK_FLAG.
- CHK_FLAG: sample data_in.
  - data_in[0]=1 → CLR_FLAG.
  - Otherwise → SEND.
  - Only bit 0 is the flag; upper bits are ignored.
- CLR_FLAG: address=FLAG_ADDR, data_out=0, wr_en=1 (exactly one cycle) → RD_CNT.
- RD_CNT: address=CNT_ADDR, wr_en=0 → CHK_CNT.
- CHK_CNT: compute the next count.
  - data_in ≥ AGG_THRESHOLD-1 → next count = 0 and set the fire indication.
  - Otherwise → next count = data_in+1.
  - Unsigned WORD_WIDTH arithmetic. A corrupt value ≥ threshold also wraps to 0 and fires.
  - → WR_CNT.
- WR_CNT: address=CNT_ADDR, data_out=next count, wr_en=1; agg_fire=1 in this cycle only when firing → FIN.
- SEND: tx_valid=1, tx_dest=latched action.
  - Stays in SEND while tx_ready=0; tx_dest must not change.
  - When tx_valid=1 and tx_ready=1 at an edge, transfer completes → FIN; tx_valid=0 the next cycle.
  - Latched action==SINK_ID with flag clear is inconsistent: set err=1, skip SEND (tx_valid never asserted) → FIN.
- FIN: done=1, wr_en=0, address=0 → IDLE. done stays 1 until en is sampled in IDLE.
- Latency from the start-sampling edge to done high:
  - Flag path: 7 cycles.
  - Send path: 4 cycles with tx_ready=1 throughout, plus one cycle per stalled cycle.
- tx_ready outside SEND is ignored. start held high after done does not retrigger without en.

Test Plan:
- Memory flag=1, counter=0, AGG_THRESHOLD=4 → exactly two writes: addr 2 ← 0, then addr 3 ← 1. No agg_fire, no tx_valid, done 7 cycles after start.
- Flag=1, counter=3 → addr 3 ← 0, agg_fire high exactly one cycle (during the counter write), done set. Repeat with counter=0x00FF → also wraps to 0 and fires.
- Flag=0, action=0x0012, tx_ready held low 5 cycles then high → tx_valid high 6 cycles with tx_dest=0x0012 stable, no memory writes, done after handshake.
- Flag=0, action=65 → err=1, tx_valid never high, done set. Next en clears err and done.
- rst pulsed during CLR_FLAG → wr_en low from the next cycle, all outputs at reset values, state IDLE. start without en is ignored.
- Back-to-back: 5 flagged dispatches (en/start each), counter starting at 0 → agg_fire once (4th), final counter=1.
